store_bus_monitor: RTL and testbench
====================================

// Module: store_bus_monitor
// PURPOSE
//   Synthesizable observer on the CPU data-memory store bus (memwrite/dataadr/writedata) of top.
//   Logs every store into a small FIFO, counts stores and cycles, and declares end-of-test:
//   PASS on a store of DONE_VALUE to DONE_ADDR, FAIL on any other value there, TIMEOUT if none arrives.
//   Self-checking partner of the processor: it consumes the bus the core produces.
// PARAMETERS
//   DEPTH      8       store-log FIFO entries (power of 2, >=2)
//   DONE_ADDR  32'd84  end-of-test store address
//   DONE_VALUE 32'd7   data that signals pass
//   TIMEOUT    20      cycles in RUN with no done-store before TMO (>=1)
// PORTS
//   clk          in   1   rising-edge clock
//   reset        in   1   synchronous, active-high reset
//   memwrite     in   1   store strobe from core, one store per cycle when high
//   dataadr      in   32  store address
//   writedata    in   32  store data
//   log_ready    in   1   consumer pops head entry when log_valid & log_ready
//   log_valid    out  1   FIFO not empty
//   log_addr     out  32  head entry address (show-ahead)
//   log_data     out  32  head entry data (show-ahead)
//   overflow     out  1   sticky: a store was dropped because the FIFO was full
//   done         out  1   FSM in PASS, FAIL or TMO
//   pass         out  1   FSM in PASS
//   fail         out  1   FSM in FAIL
//   timeout      out  1   FSM in TMO
//   store_count  out  16  stores seen in RUN, saturating at 16'hFFFF
//   cycle_count  out  16  cycles spent in RUN, saturating at 16'hFFFF
// BEHAVIOUR
//   Reset (sync, any state): FSM=RUN; FIFO emptied; all outputs 0; log_addr/log_data 0.
//   FSM: RUN -> PASS | FAIL | TMO; terminal states hold until reset. All flags registered.
//   RUN, each cycle: cycle_count+1 (saturating).
//   RUN & memwrite: store_count+1 (saturating); push {dataadr,writedata}.
//     FIFO full and no pop this cycle: entry dropped, overflow<=1.
//     FIFO full with pop this cycle: push accepted, no overflow.
//   RUN & memwrite & dataadr==DONE_ADDR: next state PASS if writedata==DONE_VALUE else FAIL.
//     That store is still counted and logged. done/pass/fail rise the following cycle.
//   RUN & cycle_count==TIMEOUT-1 & no done-store this cycle: next state TMO.
//     A done-store in the same cycle wins over timeout.
//   Terminal states: memwrite ignored (no push, no count); counters frozen; FIFO keeps draining.
//   FIFO: in-order, show-ahead. Pop on an empty FIFO is a no-op.
//     Pointers wrap modulo DEPTH. Count width clog2(DEPTH)+1.
//   Latency: store to log_valid is 1 cycle (registered push).
//   Reset mid-run or in a terminal state discards log, counters and flags.
// STRUCTURE
//   Package store_mon_pkg: state enum {RUN,PASS,FAIL,TMO}; defaults for DONE_ADDR/DONE_VALUE/TIMEOUT.
//   Sub-module sync_fifo (#WIDTH=64, #DEPTH): push/pop/full/empty, show-ahead head.
//     Same clk/reset. Monitor holds the FSM, counters and overflow flag.
// TESTING
//   1. Reset, store (84,7) in 3rd RUN cycle -> next cycle done=1, pass=1;
//      store_count=1; log pops (84,7).
//   2. Store (84,5) -> fail=1, pass=0. Later store (84,7) ignored; store_count stays 1.
//   3. No stores, TIMEOUT=20 -> timeout=done=1 after 20 RUN cycles; cycle_count=20; log empty.
//   4. log_ready=0, 9 stores (addr 0,4,..,32) with DEPTH=8 -> overflow=1; store_count=9;
//      pops yield addr 0..28 in order; addr 32 is lost.
//   5. Full FIFO, store + pop in same cycle -> overflow stays 0; new entry is last.
//      Done-store in the cycle cycle_count==19 -> PASS, not TMO.
//   6. Reset asserted one cycle while in PASS with 3 logged entries -> all outputs 0,
//      log_valid=0. Then store (84,7) -> pass again.

Source files
------------

// File: rtl/store_bus_monitor_pkg.sv
// Shared types and defaults for the store-bus monitor: FSM state encoding,
// end-of-test defaults and the saturating counter helper.
package store_mon_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2,
        ST_TMO  = 2'd3
    } mon_state_e;

    localparam logic [31:0] DEF_DONE_ADDR  = 32'd84;
    localparam logic [31:0] DEF_DONE_VALUE = 32'd7;
    localparam int          DEF_TIMEOUT    = 20;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            return value;
        end else begin
            return value + 16'd1;
        end
    endfunction

endpackage

// File: rtl/store_bus_monitor_if.sv
// Store bus from the core plus the store-log drain port. The master side is
// the core/consumer environment, the slave side is the monitor.
interface store_bus_monitor_if;

    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic        log_ready;
    logic        log_valid;
    logic [31:0] log_addr;
    logic [31:0] log_data;

    modport master (
        output memwrite, dataadr, writedata, log_ready,
        input  log_valid, log_addr, log_data
    );

    modport slave (
        input  memwrite, dataadr, writedata, log_ready,
        output log_valid, log_addr, log_data
    );

endinterface

// File: rtl/store_bus_monitor_sync_fifo.sv
// Show-ahead synchronous FIFO. A push into a full FIFO is accepted only when a
// pop happens in the same cycle; a pop on an empty FIFO does nothing.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_rdata
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == CW'(0));
    assign o_full    = (r_count == CW'(DEPTH));
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    // Head is forced to zero while empty so stale storage never shows.
    assign o_rdata   = o_empty ? {WIDTH{1'b0}} : r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

endmodule

// File: rtl/store_bus_monitor.sv
// Observer on the core's data-memory store bus. Logs stores into a FIFO,
// counts stores and run cycles, and decides pass/fail/timeout for the test.
module store_bus_monitor
    import store_mon_pkg::*;
#(
    parameter int          DEPTH      = 8,
    parameter logic [31:0] DONE_ADDR  = DEF_DONE_ADDR,
    parameter logic [31:0] DONE_VALUE = DEF_DONE_VALUE,
    parameter int          TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 reset,
    store_bus_monitor_if.slave   bus,
    output logic                 overflow,
    output logic                 done,
    output logic                 pass,
    output logic                 fail,
    output logic                 timeout,
    output logic [15:0]          store_count,
    output logic [15:0]          cycle_count
);

    mon_state_e  r_state;
    mon_state_e  w_state_next;
    logic        r_overflow;
    logic        r_pass;
    logic        r_fail;
    logic        r_timeout;
    logic [15:0] r_store_count;
    logic [15:0] r_cycle_count;
    logic        w_in_run;
    logic        w_store;
    logic        w_done_store;
    logic        w_last_cycle;
    logic        w_pass_next;
    logic        w_fail_next;
    logic        w_tmo_next;
    logic        w_full;
    logic        w_empty;
    logic        w_pop;
    logic [63:0] w_head;

    assign w_in_run     = (r_state == ST_RUN);
    assign w_store      = w_in_run & bus.memwrite;
    assign w_done_store = w_store & (bus.dataadr == DONE_ADDR);
    assign w_last_cycle = (r_cycle_count == 16'(TIMEOUT - 1));
    assign w_pop        = bus.log_ready & ~w_empty;

    sync_fifo #(
        .WIDTH (64),
        .DEPTH (DEPTH)
    ) u_log (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_store),
        .i_wdata ({bus.dataadr, bus.writedata}),
        .i_pop   (bus.log_ready),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_rdata (w_head)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: a done-store takes priority over the timeout.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_done_store) begin
                    w_state_next = (bus.writedata == DONE_VALUE) ? ST_PASS : ST_FAIL;
                end else if (w_last_cycle) begin
                    w_state_next = ST_TMO;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            ST_PASS: w_state_next = ST_PASS;
            ST_FAIL: w_state_next = ST_FAIL;
            ST_TMO:  w_state_next = ST_TMO;
            default: w_state_next = ST_RUN;
        endcase
    end

    // Output decode from the next state so the registered flags line up with it.
    always_comb begin
        w_pass_next = 1'b0;
        w_fail_next = 1'b0;
        w_tmo_next  = 1'b0;
        case (w_state_next)
            ST_PASS: w_pass_next = 1'b1;
            ST_FAIL: w_fail_next = 1'b1;
            ST_TMO:  w_tmo_next  = 1'b1;
            default: w_pass_next = 1'b0;
        endcase
    end

    // Registered end-of-test flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pass    <= 1'b0;
            r_fail    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_pass    <= w_pass_next;
            r_fail    <= w_fail_next;
            r_timeout <= w_tmo_next;
        end
    end

    // Store and cycle counters, frozen once the test has ended.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_store_count <= 16'd0;
            r_cycle_count <= 16'd0;
        end else if (w_in_run) begin
            r_cycle_count <= sat_inc16(r_cycle_count);
            if (w_store) begin
                r_store_count <= sat_inc16(r_store_count);
            end
        end
    end

    // Sticky overflow: a store found the log full with no simultaneous pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_store & w_full & ~w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    assign bus.log_valid = ~w_empty;
    assign bus.log_addr  = w_head[63:32];
    assign bus.log_data  = w_head[31:0];
    assign overflow      = r_overflow;
    assign pass          = r_pass;
    assign fail          = r_fail;
    assign timeout       = r_timeout;
    assign done          = r_pass | r_fail | r_timeout;
    assign store_count   = r_store_count;
    assign cycle_count   = r_cycle_count;

endmodule

// File: tb/tb_store_bus_monitor.sv
// Self-checking bench for store_bus_monitor: constant vector table, directed
// corner-case sequences and randomized traffic against a queue-based model.
module tb_store_bus_monitor;

    localparam int          DEPTH      = 8;
    localparam logic [31:0] DONE_ADDR  = 32'd84;
    localparam logic [31:0] DONE_VALUE = 32'd7;
    localparam int          TIMEOUT    = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic        overflow, done, pass, fail, timeout;
    logic [15:0] store_count, cycle_count;

    int n_tests = 0;
    int n_fail  = 0;

    store_bus_monitor_if bus ();

    store_bus_monitor #(
        .DEPTH      (DEPTH),
        .DONE_ADDR  (DONE_ADDR),
        .DONE_VALUE (DONE_VALUE),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .overflow    (overflow),
        .done        (done),
        .pass        (pass),
        .fail        (fail),
        .timeout     (timeout),
        .store_count (store_count),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    // Reference model: 0=running, 1=pass, 2=fail, 3=timeout.
    logic [63:0] m_q[$];
    int          m_st;
    logic        m_ovf;
    int          m_sc;
    int          m_cc;

    typedef struct {
        logic        rst;
        logic        mw;
        logic [31:0] adr;
        logic [31:0] wd;
        logic        rdy;
        logic        e_valid;
        logic [31:0] e_addr;
        logic [31:0] e_data;
        logic        e_done;
        logic        e_pass;
        logic        e_fail;
        logic [15:0] e_sc;
        logic [15:0] e_cc;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_clock(input logic rst, input logic mw, input logic [31:0] a,
                               input logic [31:0] d, input logic rdy);
        bit do_pop;
        bit do_push;
        do_pop  = 1'b0;
        do_push = 1'b0;
        if (rst) begin
            m_q.delete();
            m_st  = 0;
            m_ovf = 1'b0;
            m_sc  = 0;
            m_cc  = 0;
        end else begin
            do_pop = rdy && (m_q.size() > 0);
            if (m_st == 0) begin
                if (mw) begin
                    if (m_sc < 65535) m_sc++;
                    if (m_q.size() == DEPTH && !do_pop) m_ovf = 1'b1;
                    else do_push = 1'b1;
                end
                if (mw && a == DONE_ADDR) m_st = (d == DONE_VALUE) ? 1 : 2;
                else if (m_cc == TIMEOUT - 1) m_st = 3;
                if (m_cc < 65535) m_cc++;
            end
            if (do_pop) void'(m_q.pop_front());
            if (do_push) m_q.push_back({a, d});
        end
    endtask

    task automatic step(input logic rst, input logic mw, input logic [31:0] a,
                        input logic [31:0] d, input logic rdy);
        reset         = rst;
        bus.memwrite  = mw;
        bus.dataadr   = a;
        bus.writedata = d;
        bus.log_ready = rdy;
        model_clock(rst, mw, a, d, rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model();
        logic [63:0] head;
        head = (m_q.size() > 0) ? m_q[0] : 64'd0;
        chk("log_valid",   32'(bus.log_valid), 32'(m_q.size() > 0));
        chk("log_addr",    bus.log_addr,       head[63:32]);
        chk("log_data",    bus.log_data,       head[31:0]);
        chk("overflow",    32'(overflow),      32'(m_ovf));
        chk("done",        32'(done),          32'(m_st != 0));
        chk("pass",        32'(pass),          32'(m_st == 1));
        chk("fail",        32'(fail),          32'(m_st == 2));
        chk("timeout",     32'(timeout),       32'(m_st == 3));
        chk("store_count", 32'(store_count),   32'(m_sc));
        chk("cycle_count", 32'(cycle_count),   32'(m_cc));
    endtask

    // Global run-time bound in case the design stalls the bench.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        bus.memwrite  = 1'b0;
        bus.dataadr   = 32'd0;
        bus.writedata = 32'd0;
        bus.log_ready = 1'b0;

        // Vector table: pass on (84,7) in third run cycle, then fail on (84,5).
        vecs[0] = '{1'b1, 1'b0, 32'd0,  32'd0, 1'b0, 1'b0, 32'd0,  32'd0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
        vecs[1] = '{1'b0, 1'b0, 32'd0,  32'd0, 1'b0, 1'b0, 32'd0,  32'd0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd1};
        vecs[2] = '{1'b0, 1'b0, 32'd0,  32'd0, 1'b0, 1'b0, 32'd0,  32'd0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd2};
        vecs[3] = '{1'b0, 1'b1, 32'd84, 32'd7, 1'b0, 1'b1, 32'd84, 32'd7, 1'b1, 1'b1, 1'b0, 16'd1, 16'd3};
        vecs[4] = '{1'b0, 1'b0, 32'd0,  32'd0, 1'b1, 1'b0, 32'd0,  32'd0, 1'b1, 1'b1, 1'b0, 16'd1, 16'd3};
        vecs[5] = '{1'b1, 1'b0, 32'd0,  32'd0, 1'b0, 1'b0, 32'd0,  32'd0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
        vecs[6] = '{1'b0, 1'b1, 32'd84, 32'd5, 1'b1, 1'b1, 32'd84, 32'd5, 1'b1, 1'b0, 1'b1, 16'd1, 16'd1};
        vecs[7] = '{1'b0, 1'b1, 32'd84, 32'd7, 1'b1, 1'b0, 32'd0,  32'd0, 1'b1, 1'b0, 1'b1, 16'd1, 16'd1};
        vecs[8] = '{1'b0, 1'b1, 32'd84, 32'd7, 1'b0, 1'b0, 32'd0,  32'd0, 1'b1, 1'b0, 1'b1, 16'd1, 16'd1};

        for (int i = 0; i < 9; i++) begin
            step(vecs[i].rst, vecs[i].mw, vecs[i].adr, vecs[i].wd, vecs[i].rdy);
            chk($sformatf("vec%0d log_valid", i),   32'(bus.log_valid),  32'(vecs[i].e_valid));
            chk($sformatf("vec%0d log_addr", i),    bus.log_addr,        vecs[i].e_addr);
            chk($sformatf("vec%0d log_data", i),    bus.log_data,        vecs[i].e_data);
            chk($sformatf("vec%0d done", i),        32'(done),           32'(vecs[i].e_done));
            chk($sformatf("vec%0d pass", i),        32'(pass),           32'(vecs[i].e_pass));
            chk($sformatf("vec%0d fail", i),        32'(fail),           32'(vecs[i].e_fail));
            chk($sformatf("vec%0d store_count", i), 32'(store_count),    32'(vecs[i].e_sc));
            chk($sformatf("vec%0d cycle_count", i), 32'(cycle_count),    32'(vecs[i].e_cc));
        end

        // Timeout with no stores at all.
        step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 19; i++) begin
            step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
            check_model();
        end
        chk("tmo early timeout", 32'(timeout), 32'd0);
        step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        chk("tmo timeout",     32'(timeout),       32'd1);
        chk("tmo done",        32'(done),          32'd1);
        chk("tmo cycle_count", 32'(cycle_count),   32'd20);
        chk("tmo log_valid",   32'(bus.log_valid), 32'd0);
        step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        chk("tmo cycle frozen", 32'(cycle_count), 32'd20);

        // Overflow: nine stores into an eight-deep log with no draining.
        step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 1'b1, 32'(4 * i), 32'(100 + i), 1'b0);
            check_model();
        end
        chk("ovf overflow",    32'(overflow),    32'd1);
        chk("ovf store_count", 32'(store_count), 32'd9);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("ovf pop%0d addr", i), bus.log_addr, 32'(4 * i));
            step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
            check_model();
        end
        chk("ovf drained", 32'(bus.log_valid), 32'd0);

        // Full log with simultaneous push and pop, then done-store on the last cycle.
        step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 32'h100 + 32'(4 * i), 32'(i), 1'b0);
        end
        step(1'b0, 1'b1, 32'h200, 32'hAB, 1'b1);
        check_model();
        chk("full pushpop overflow", 32'(overflow), 32'd0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("full pop%0d addr", i), bus.log_addr,
                (i < 7) ? 32'h104 + 32'(4 * i) : 32'h200);
            step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        end
        for (int k = 0; k < 30 && m_cc != TIMEOUT - 1; k++) begin
            step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        end
        chk("edge pre cycle_count", 32'(cycle_count), 32'(TIMEOUT - 1));
        step(1'b0, 1'b1, DONE_ADDR, DONE_VALUE, 1'b0);
        chk("edge pass",    32'(pass),    32'd1);
        chk("edge timeout", 32'(timeout), 32'd0);
        check_model();

        // Reset while in PASS with three logged entries.
        step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        step(1'b0, 1'b1, 32'd8,  32'd1, 1'b0);
        step(1'b0, 1'b1, 32'd12, 32'd2, 1'b0);
        step(1'b0, 1'b1, 32'd84, 32'd7, 1'b0);
        chk("rst6 pre pass", 32'(pass), 32'd1);
        check_model();
        step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        chk("rst6 log_valid",   32'(bus.log_valid), 32'd0);
        chk("rst6 log_addr",    bus.log_addr,       32'd0);
        chk("rst6 log_data",    bus.log_data,       32'd0);
        chk("rst6 overflow",    32'(overflow),      32'd0);
        chk("rst6 done",        32'(done),          32'd0);
        chk("rst6 pass",        32'(pass),          32'd0);
        chk("rst6 store_count", 32'(store_count),   32'd0);
        chk("rst6 cycle_count", 32'(cycle_count),   32'd0);
        step(1'b0, 1'b1, 32'd84, 32'd7, 1'b0);
        chk("rst6 pass again", 32'(pass), 32'd1);
        check_model();

        // Randomized traffic against the model.
        for (int run = 0; run < 15; run++) begin
            step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
            check_model();
            for (int c = 0; c < 40; c++) begin
                logic        mw;
                logic [31:0] a;
                logic [31:0] d;
                logic        rdy;
                mw  = ($urandom_range(0, 9) < 6);
                a   = ($urandom_range(0, 11) == 0) ? DONE_ADDR : (32'($urandom_range(0, 40)) << 2);
                d   = ($urandom_range(0, 1) == 0) ? DONE_VALUE : 32'($urandom);
                rdy = ($urandom_range(0, 2) == 0);
                step(1'b0, mw, a, d, rdy);
                check_model();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
